// File: rtl/multi_collision_engine.sv
`default_nettype none
// ============================================================================
//  Module   : multi_collision_engine
//  Purpose  : Time-multiplexed collision engine for NUM_ENT sprites
//             (entity 0 = player, 1..NUM_ENT-1 = enemies). One pass latches
//             all entity state, probes a shared walkability ROM at the four
//             corners of every entity's next position, then evaluates
//             player-vs-enemy overlap and sword reach, and pulses done.
//  Ports    : clock, resetn    - clock, async active-low reset
//             start            - request a pass (sampled in IDLE only)
//             ent_en           - per-entity enable mask
//             pos_x/pos_y/dir  - packed per-entity position and move code
//             attack/facing    - player attack request and facing
//             rom_addr/rom_q   - external map ROM port (1 = walkable)
//             busy/done        - pass in progress / one-cycle completion
//             map_col/ent_col/hit - per-entity results, valid from done
//  Revision : 1.0  initial release
// ============================================================================
module multi_collision_engine #(
    parameter int NUM_ENT      = 4,
    parameter int SPRITE       = 16,
    parameter int STEP         = 1,
    parameter int MAP_W        = 256,
    parameter int MAP_H        = 176,
    parameter int ROM_LAT      = 1,
    parameter int ATTACK_RANGE = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [NUM_ENT-1:0]     ent_en,
    input  logic [9*NUM_ENT-1:0]   pos_x,
    input  logic [8*NUM_ENT-1:0]   pos_y,
    input  logic [3*NUM_ENT-1:0]   dir,
    input  logic                   attack,
    input  logic [2:0]             facing,
    output logic [16:0]            rom_addr,
    input  logic                   rom_q,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_ENT-1:0]     map_col,
    output logic [NUM_ENT-1:0]     ent_col,
    output logic [NUM_ENT-1:0]     hit
);

    localparam int c_IW     = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int c_NPROBE = 4 * NUM_ENT;
    localparam int c_CW     = $clog2(c_NPROBE + ROM_LAT + 1);

    localparam logic [c_CW-1:0] c_PROBE_LAST = c_CW'(c_NPROBE + ROM_LAT - 1);
    localparam logic [c_CW-1:0] c_PAIR_LAST  = c_CW'(NUM_ENT - 2);
    localparam logic [c_CW-1:0] c_LAT        = c_CW'(ROM_LAT);
    localparam logic [c_CW-1:0] c_NPROBE_W   = c_CW'(c_NPROBE);

    localparam logic [2:0] c_D_UP    = 3'd2;
    localparam logic [2:0] c_D_DOWN  = 3'd3;
    localparam logic [2:0] c_D_LEFT  = 3'd4;
    localparam logic [2:0] c_D_RIGHT = 3'd5;

    localparam logic        [8:0] c_SPR9  = 9'(SPRITE);
    localparam logic signed [9:0] c_SPR10 = 10'(SPRITE);
    localparam logic signed [9:0] c_RNG10 = 10'(ATTACK_RANGE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_PROBE = 3'd2,
        S_PAIR  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [NUM_ENT-1:0]  r_en;
    logic [8:0]          r_x   [NUM_ENT];
    logic [7:0]          r_y   [NUM_ENT];
    logic [2:0]          r_dir [NUM_ENT];
    logic                r_attack;
    logic [2:0]          r_facing;
    logic [NUM_ENT-1:0]  r_and;       // running AND of corner walkability
    logic [NUM_ENT-1:0]  r_ent_pend;
    logic [NUM_ENT-1:0]  r_hit_pend;

    // ------------------------------------------------------------------
    // Per-entity next position and out-of-bounds detection
    // ------------------------------------------------------------------
    logic [9:0]          w_nx [NUM_ENT];
    logic [8:0]          w_ny [NUM_ENT];
    logic [NUM_ENT-1:0]  w_exc;

    for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
        assign w_nx[gi] = (r_dir[gi] == c_D_LEFT)  ? 10'(r_x[gi]) - 10'(STEP) :
                          (r_dir[gi] == c_D_RIGHT) ? 10'(r_x[gi]) + 10'(STEP) :
                                                     10'(r_x[gi]);
        assign w_ny[gi] = (r_dir[gi] == c_D_UP)    ? 9'(r_y[gi]) - 9'(STEP) :
                          (r_dir[gi] == c_D_DOWN)  ? 9'(r_y[gi]) + 9'(STEP) :
                                                     9'(r_y[gi]);
        assign w_exc[gi] =
            ((r_dir[gi] == c_D_LEFT)  && (10'(r_x[gi]) < 10'(STEP))) ||
            ((r_dir[gi] == c_D_UP)    && (9'(r_y[gi])  < 9'(STEP)))  ||
            ((r_dir[gi] == c_D_RIGHT) && ((11'(r_x[gi]) + 11'(SPRITE + STEP)) > 11'(MAP_W))) ||
            ((r_dir[gi] == c_D_DOWN)  && ((10'(r_y[gi]) + 10'(SPRITE + STEP)) > 10'(MAP_H)));
    end

    // ------------------------------------------------------------------
    // Probe address: rom_addr is registered, so the address for probe p is
    // computed one cycle ahead (LATCH computes probe 0, PROBE cycle p
    // computes probe p+1). Excepted entities drive address 0.
    // ------------------------------------------------------------------
    logic [c_CW-1:0]  w_psel;
    logic [c_IW-1:0]  w_pent;
    logic [9:0]       w_cx;
    logic [8:0]       w_cy;
    logic [16:0]      w_addr;
    logic [c_IW-1:0]  w_aent;

    always_comb begin
        w_psel = (r_state == S_PROBE) ? r_cnt + c_CW'(1) : '0;
        w_pent = w_psel[c_IW+1:2];
        w_cx   = w_nx[w_pent] + (w_psel[0] ? 10'(SPRITE - 1) : 10'd0);
        w_cy   = w_ny[w_pent] + (w_psel[1] ? 9'(SPRITE - 1)  : 9'd0);
        w_addr = '0;
        if ((w_psel < c_NPROBE_W) && !w_exc[w_pent])
            w_addr = 17'(32'(w_cy) * 32'(MAP_W) + 32'(w_cx));
        // rom_q in PROBE cycle k answers the probe issued ROM_LAT cycles earlier
        w_aent = c_IW'((r_cnt - c_LAT) >> 2);
    end

    // ------------------------------------------------------------------
    // Pair evaluation: one enemy per PAIR cycle against the player
    // ------------------------------------------------------------------
    logic [c_IW-1:0]     w_ei;
    logic [8:0]          w_xi;
    logic [7:0]          w_yi;
    logic [8:0]          w_dx;
    logic [8:0]          w_dy;
    logic signed [9:0]   w_gap_up;
    logic signed [9:0]   w_gap_dn;
    logic signed [9:0]   w_gap_lf;
    logic signed [9:0]   w_gap_rt;
    logic                w_reach;
    logic                w_col_now;
    logic                w_hit_now;
    logic [NUM_ENT-1:0]  w_sel;
    logic [NUM_ENT-1:0]  w_ent_next;
    logic [NUM_ENT-1:0]  w_hit_next;

    always_comb begin
        w_ei     = c_IW'(r_cnt + c_CW'(1));
        w_xi     = r_x[w_ei];
        w_yi     = r_y[w_ei];
        w_dx     = (r_x[0] >= w_xi) ? r_x[0] - w_xi : w_xi - r_x[0];
        w_dy     = (r_y[0] >= w_yi) ? 9'(r_y[0] - w_yi) : 9'(w_yi - r_y[0]);
        // Gaps may go negative when sprites overlap; that still counts as in reach
        w_gap_up = 10'(r_y[0]) - 10'(w_yi) - c_SPR10;
        w_gap_dn = 10'(w_yi) - 10'(r_y[0]) - c_SPR10;
        w_gap_lf = 10'(r_x[0]) - 10'(w_xi) - c_SPR10;
        w_gap_rt = 10'(w_xi) - 10'(r_x[0]) - c_SPR10;
        case (r_facing)
            c_D_UP:    w_reach = (w_dx < c_SPR9) && (w_yi < r_y[0]) && (w_gap_up < c_RNG10);
            c_D_DOWN:  w_reach = (w_dx < c_SPR9) && (w_yi > r_y[0]) && (w_gap_dn < c_RNG10);
            c_D_LEFT:  w_reach = (w_dy < c_SPR9) && (w_xi < r_x[0]) && (w_gap_lf < c_RNG10);
            c_D_RIGHT: w_reach = (w_dy < c_SPR9) && (w_xi > r_x[0]) && (w_gap_rt < c_RNG10);
            default:   w_reach = 1'b0;
        endcase
        w_col_now  = r_en[0] & r_en[w_ei] & (w_dx < c_SPR9) & (w_dy < c_SPR9);
        w_hit_now  = r_en[0] & r_en[w_ei] & r_attack & w_reach;
        w_sel      = NUM_ENT'(1) << w_ei;
        w_ent_next = r_ent_pend | (w_col_now ? w_sel : '0);
        w_hit_next = r_hit_pend | (w_hit_now ? w_sel : '0);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_en       <= '0;
            r_attack   <= 1'b0;
            r_facing   <= '0;
            r_and      <= '0;
            r_ent_pend <= '0;
            r_hit_pend <= '0;
            for (int k = 0; k < NUM_ENT; k++) begin
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_dir[k] <= '0;
            end
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            map_col    <= '0;
            ent_col    <= '0;
            hit        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_en     <= ent_en;
                        r_attack <= attack;
                        r_facing <= facing;
                        for (int k = 0; k < NUM_ENT; k++) begin
                            r_x[k]   <= pos_x[9*k +: 9];
                            r_y[k]   <= pos_y[8*k +: 8];
                            r_dir[k] <= dir[3*k +: 3];
                        end
                        busy    <= 1'b1;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    rom_addr   <= w_addr;
                    r_and      <= '1;
                    r_ent_pend <= '0;
                    r_hit_pend <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_PROBE;
                end
                S_PROBE: begin
                    rom_addr <= w_addr;
                    if (r_cnt >= c_LAT)
                        r_and[w_aent] <= r_and[w_aent] & rom_q;
                    if (r_cnt == c_PROBE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_PAIR;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_PAIR: begin
                    r_ent_pend <= w_ent_next;
                    r_hit_pend <= w_hit_next;
                    if (r_cnt == c_PAIR_LAST) begin
                        map_col <= r_en & (~r_and | w_exc);
                        ent_col <= w_ent_next;
                        hit     <= w_hit_next;
                        done    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_collision_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_collision_engine
//  Purpose  : Directed self-checking bench for multi_collision_engine with a
//             one-cycle-latency map ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_collision_engine;

    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_UP    = 3'd2;
    localparam logic [2:0] D_DOWN  = 3'd3;
    localparam logic [2:0] D_LEFT  = 3'd4;
    localparam logic [2:0] D_RIGHT = 3'd5;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [3:0]  ent_en;
    logic [35:0] pos_x;
    logic [31:0] pos_y;
    logic [11:0] dir;
    logic        attack;
    logic [2:0]  facing;
    logic [16:0] rom_addr;
    logic        rom_q;
    logic        busy;
    logic        done;
    logic [3:0]  map_col;
    logic [3:0]  ent_col;
    logic [3:0]  hit;

    int          n_checks;
    int          n_errors;
    int          rom_mode;
    int          done_at;
    int          n_done;
    logic [3:0]  cap_map;
    logic [3:0]  cap_ent;
    logic [3:0]  cap_hit;
    logic        busy_after;
    logic [16:0] addr_log [0:47];
    logic [16:0] addr_or;

    multi_collision_engine #(
        .NUM_ENT(4), .SPRITE(16), .STEP(1), .MAP_W(256), .MAP_H(176),
        .ROM_LAT(1), .ATTACK_RANGE(8)
    ) u_dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .ent_en   (ent_en),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .dir      (dir),
        .attack   (attack),
        .facing   (facing),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .busy     (busy),
        .done     (done),
        .map_col  (map_col),
        .ent_col  (ent_col),
        .hit      (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Map ROM: mode 1 blocks the pixel column x=116
    always @(posedge clock)
        rom_q <= (rom_mode == 1 && rom_addr[7:0] == 8'd116) ? 1'b0 : 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_ent(input int i, input int x, input int y, input logic [2:0] d);
        pos_x[9*i +: 9] = 9'(x);
        pos_y[8*i +: 8] = 8'(y);
        dir[3*i +: 3]   = d;
    endtask

    // Runs one pass and logs outputs per cycle; k counts cycles after the
    // edge that samples start. Optional extra start pulse at pulse_k and an
    // input scramble at chg_k.
    task automatic run_pass(input bit issue, input int pulse_k, input int chg_k);
        done_at    = -1;
        n_done     = 0;
        busy_after = 1'b1;
        if (issue) begin
            @(negedge clock);
            start = 1'b1;
        end
        @(posedge clock);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            addr_log[k] = rom_addr;
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    cap_map = map_col;
                    cap_ent = ent_col;
                    cap_hit = hit;
                end
            end
            if (done_at >= 0 && k == done_at + 1) busy_after = busy;
            if (k == chg_k) begin
                attack = 1'b0;
                facing = D_NONE;
                ent_en = 4'b0000;
                pos_x  = '0;
                pos_y  = '0;
            end
            if (k == 1 || k == pulse_k + 1) start = 1'b0;
            if (k == pulse_k) start = 1'b1;
        end
    endtask

    task automatic cfg_sword();
        rom_mode = 0;
        ent_en   = 4'b0111;
        attack   = 1'b1;
        facing   = D_RIGHT;
        set_ent(0, 100, 100, D_NONE);
        set_ent(1, 120, 100, D_NONE);
        set_ent(2, 110, 105, D_NONE);
        set_ent(3, 105, 100, D_NONE);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rom_mode = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        ent_en   = 4'b1111;
        pos_x    = '0;
        pos_y    = '0;
        dir      = '0;
        attack   = 1'b0;
        facing   = D_NONE;

        repeat (3) @(negedge clock);
        check_eq("rst_busy",    32'(busy),     0);
        check_eq("rst_done",    32'(done),     0);
        check_eq("rst_map_col", 32'(map_col),  0);
        check_eq("rst_ent_col", 32'(ent_col),  0);
        check_eq("rst_hit",     32'(hit),      0);
        check_eq("rst_rom_addr",32'(rom_addr), 0);
        resetn = 1'b1;

        // Open field, player walking right; late start pulse must be ignored
        set_ent(0, 100, 100, D_RIGHT);
        set_ent(1, 10, 10, D_NONE);
        set_ent(2, 200, 10, D_NONE);
        set_ent(3, 10, 150, D_NONE);
        run_pass(1'b1, 21, 0);
        check_eq("open_done_at",  32'(done_at),    22);
        check_eq("open_n_done",   32'(n_done),     1);
        check_eq("open_busy_post",32'(busy_after), 0);
        check_eq("open_map_col",  32'(cap_map),    0);
        check_eq("open_ent_col",  32'(cap_ent),    0);
        check_eq("open_hit",      32'(cap_hit),    0);
        check_eq("open_addr_p0",  32'(addr_log[2]), 25701);
        check_eq("open_addr_p1",  32'(addr_log[3]), 25716);

        // Blocked column x=116: right move touches it, left move does not
        rom_mode = 1;
        set_ent(0, 100, 50, D_RIGHT);
        run_pass(1'b1, 0, 0);
        check_eq("wall_right_map", 32'(cap_map), 4'b0001);
        set_ent(0, 100, 50, D_LEFT);
        run_pass(1'b1, 0, 0);
        check_eq("wall_left_map",  32'(cap_map), 4'b0000);

        // Edge exceptions on enemy 1 (left at x=0) and enemy 2 (down at y=160)
        rom_mode = 0;
        set_ent(0, 100, 100, D_NONE);
        set_ent(1, 0, 50, D_LEFT);
        set_ent(2, 50, 160, D_DOWN);
        set_ent(3, 10, 150, D_NONE);
        run_pass(1'b1, 0, 0);
        addr_or = '0;
        for (int k = 6; k <= 13; k++) addr_or = addr_or | addr_log[k];
        check_eq("edge_map_col",   32'(cap_map), 4'b0110);
        check_eq("edge_addr_zero", 32'(addr_or), 0);
        check_eq("edge_addr_e3c0", 32'(addr_log[14]), 38410);
        check_eq("edge_addr_e3c3", 32'(addr_log[17]), 42265);

        // Sword to the right; enemy 3 disabled though overlapping
        cfg_sword();
        run_pass(1'b1, 0, 0);
        check_eq("sword_hit",     32'(cap_hit), 4'b0110);
        check_eq("sword_ent_col", 32'(cap_ent), 4'b0100);
        check_eq("sword_map_col", 32'(cap_map), 4'b0000);
        attack = 1'b0;
        run_pass(1'b1, 0, 0);
        check_eq("noatk_hit",     32'(cap_hit), 4'b0000);
        check_eq("noatk_ent_col", 32'(cap_ent), 4'b0100);

        // Player disabled: no overlap or hit reported
        cfg_sword();
        ent_en = 4'b0110;
        run_pass(1'b1, 0, 0);
        check_eq("p_off_hit",     32'(cap_hit), 4'b0000);
        check_eq("p_off_ent_col", 32'(cap_ent), 4'b0000);

        // Facing up: range boundary (gap 7 hits, gap 8 misses), dx=15 overlaps
        ent_en = 4'b1111;
        attack = 1'b1;
        facing = D_UP;
        set_ent(0, 100, 100, D_NONE);
        set_ent(1, 105, 77, D_NONE);
        set_ent(2, 100, 76, D_NONE);
        set_ent(3, 115, 100, D_NONE);
        run_pass(1'b1, 0, 0);
        check_eq("up_hit",     32'(cap_hit), 4'b0010);
        check_eq("up_ent_col", 32'(cap_ent), 4'b1000);

        // Mid-pass start pulse and input scramble after LATCH
        cfg_sword();
        run_pass(1'b1, 10, 3);
        check_eq("latch_done_at", 32'(done_at), 22);
        check_eq("latch_n_done",  32'(n_done),  1);
        check_eq("latch_hit",     32'(cap_hit), 4'b0110);
        check_eq("latch_ent_col", 32'(cap_ent), 4'b0100);

        // Reset asserted in PROBE with start held
        cfg_sword();
        run_pass(1'b1, 0, 0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        repeat (5) @(negedge clock);
        check_eq("mid_busy_pre", 32'(busy), 1);
        resetn = 1'b0;
        #1;
        check_eq("mid_busy",     32'(busy),     0);
        check_eq("mid_done",     32'(done),     0);
        check_eq("mid_map_col",  32'(map_col),  0);
        check_eq("mid_ent_col",  32'(ent_col),  0);
        check_eq("mid_hit",      32'(hit),      0);
        check_eq("mid_rom_addr", 32'(rom_addr), 0);
        @(negedge clock);
        check_eq("mid_busy_held", 32'(busy), 0);
        check_eq("mid_hit_held",  32'(hit),  0);
        resetn = 1'b1;
        run_pass(1'b0, 0, 0);
        check_eq("rel_done_at", 32'(done_at), 22);
        check_eq("rel_n_done",  32'(n_done),  1);
        check_eq("rel_hit",     32'(cap_hit), 4'b0110);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_collision_engine.md
Name: multi_collision_engine

Overview:
Parametrised, time-multiplexed collision engine for NUM_ENT sprites; entity 0 is the player and entities 1..NUM_ENT-1 are enemies. On start it latches every entity's position and intended move, then probes a shared single-port walkability map ROM at the four corners of each entity's next position. It then checks player-vs-enemy overlap and sword hits, and pulses done. It sits between the game control FSM and the character/enemy movement logic, and drives the external map ROM.

Parameters:
NUM_ENT, 4, entity count (2..8); index 0 is the player
SPRITE, 16, sprite edge in pixels (square)
STEP, 1, move distance per update in pixels
MAP_W, 256, map width in pixels
MAP_H, 176, map height in pixels
ROM_LAT, 1, map ROM read latency in cycles (1..2)
ATTACK_RANGE, 8, reach of the player's attack in pixels

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  request one evaluation pass; sampled only in IDLE
ent_en  in  NUM_ENT  per-entity enable mask
pos_x  in  9*NUM_ENT  packed x, entity i at [9i+8:9i]
pos_y  in  8*NUM_ENT  packed y, entity i at [8i+7:8i]
dir  in  3*NUM_ENT  packed move code: 0 NONE, 1 ATTACK, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT
attack  in  1  player attacking
facing  in  3  player facing, same encoding as dir
rom_addr  out  17  map address
rom_q  in  1  map data; 1 = walkable, 0 = blocked
busy  out  1  high from LATCH through DONE
done  out  1  one-cycle pulse; results valid from this cycle
map_col  out  NUM_ENT  entity i's move is blocked
ent_col  out  NUM_ENT  player overlaps entity i; bit 0 is always 0
hit  out  NUM_ENT  player attack reaches entity i; bit 0 is always 0

Behaviour:
- Reset: async clear. State=IDLE; busy, done, map_col, ent_col, hit, rom_addr and all internal registers = 0.
- FSM: IDLE -(start)-> LATCH (1 cycle) -> PROBE -> PAIR -> DONE (1 cycle) -> IDLE.
- start is ignored outside IDLE. Inputs are latched in LATCH; later input changes do not affect the pass in progress.
- Next position (nx,ny): pos shifted by STEP in the move direction. NONE and ATTACK use the current position.
- Corners: (nx,ny), (nx+SPRITE-1,ny), (nx,ny+SPRITE-1), (nx+SPRITE-1,ny+SPRITE-1).
- Address: y*MAP_W + x, 17 bits.
- Edge exception: the move is out of bounds if
  - LEFT with x<STEP, or
  - UP with y<STEP, or
  - RIGHT with x+SPRITE+STEP>MAP_W, or
  - DOWN with y+SPRITE+STEP>MAP_H.
  On an exception the probe addresses are forced to 0 and map_col[i]=1 regardless of ROM data.
- PROBE: issues one address per cycle, entity-major and corner order as listed above, 4*NUM_ENT issue cycles, then ROM_LAT drain cycles. Each rom_q return is AND-accumulated per entity. map_col[i] = ~AND4 | exception.
- PAIR: NUM_ENT-1 cycles, one enemy per cycle, using latched current positions.
  - dx = |x0-xi|, dy = |y0-yi|, computed unsigned at 9 bits.
  - ent_col[i] = dx<SPRITE && dy<SPRITE.
  - hit[i] requires attack=1 and a directional condition. The gap is computed signed at 10 bits, and a negative gap counts as in range:
    - UP: dx<SPRITE, yi<y0, and y0-yi-SPRITE < ATTACK_RANGE.
    - DOWN: dx<SPRITE, yi>y0, and yi-y0-SPRITE < ATTACK_RANGE.
    - LEFT and RIGHT: the same conditions on the x axis, with dy<SPRITE.
    - Any other facing value gives 0.
- Disabled entities: still consume their cycles, so latency is fixed. Their map_col, ent_col and hit bits are 0. If ent_en[0]=0, every ent_col and hit bit is 0.
- Result registers update only in DONE and hold until the next DONE.
- Latency: done is high exactly 5*NUM_ENT+ROM_LAT+1 cycles after the cycle in which start was sampled; 22 for the defaults. A new start is accepted in the cycle after done.
- resetn asserted mid-pass: immediate return to IDLE; no done pulse; outputs are cleared.

Test Plan:
1. Reset while in PROBE with start held -> all outputs 0 while resetn=0. After release with start=1, done arrives 22 cycles later.
2. All-walkable ROM; player at (100,100) RIGHT; enemies at (10,10), (200,10), (10,150) NONE -> map_col=0000, ent_col=0, hit=0. done pulses for exactly 1 cycle at +22.
3. ROM column x=116 blocked; player at (100,50) RIGHT -> map_col[0]=1. The same setup with LEFT -> map_col[0]=0.
4. Enemy1 at x=0 LEFT and enemy2 at y=160 DOWN, all-walkable ROM -> map_col=0110, with rom_addr=0 on the excepted probes.
5. Player at (100,100), facing RIGHT, attack=1; enemy1 at (120,100); enemy2 at (110,105); enemy3 disabled and overlapping -> hit=0110, ent_col=0100. The same with attack=0 -> hit=0000.
6. start pulsed during busy -> ignored, exactly one done. Inputs changed after LATCH -> results reflect the latched values.
